// File: rtl/dtw_pkg.sv
// Shared types and helpers for the DTW query dispatcher / result collector.
package dtw_pkg;

  typedef enum logic {
    D_IDLE   = 1'b0,
    D_STREAM = 1'b1
  } disp_state_e;

  typedef enum logic {
    C_IDLE = 1'b0,
    C_PKT  = 1'b1
  } coll_state_e;

  // Core-ID width; never narrower than one bit.
  function automatic int unsigned cid_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dtw_rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, wrapping; purely combinational.
module dtw_rr_arbiter
  import dtw_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IW = cid_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          gnt_vld,
  output logic [IW-1:0] gnt_idx
);

  localparam int unsigned CW = IW + 1;

  logic [CW-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + CW'(i);
      if (cand >= CW'(N)) cand = cand - CW'(N);
      if (req[cand[IW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/dtw_multi_dispatch.sv
// Hands whole query packets to idle DTW cores round-robin and merges their
// result packets onto one stream tagged with the source core ID.
module dtw_multi_dispatch
  import dtw_pkg::*;
#(
  parameter int unsigned N_CORES = 4,
  parameter int unsigned AXIS_W  = 32,
  localparam int unsigned CID_W  = cid_w(N_CORES)
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        en,
  input  logic                        clr,
  input  logic [AXIS_W-1:0]           s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  output logic                        s_axis_tready,
  output logic [AXIS_W-1:0]           core_src_data,
  output logic [N_CORES-1:0]          core_src_wren,
  input  logic [N_CORES-1:0]          core_src_full,
  input  logic [N_CORES-1:0]          core_busy,
  input  logic [N_CORES*AXIS_W-1:0]   core_res_data,
  input  logic [N_CORES-1:0]          core_res_valid,
  input  logic [N_CORES-1:0]          core_res_last,
  output logic [N_CORES-1:0]          core_res_ready,
  output logic [AXIS_W-1:0]           m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  output logic [CID_W-1:0]            m_axis_tuser,
  input  logic                        m_axis_tready,
  output logic [N_CORES-1:0]          stat_owned,
  output logic [31:0]                 stat_q_cnt,
  output logic [31:0]                 stat_r_cnt
);

  disp_state_e          dstate;
  coll_state_e          cstate;
  logic [CID_W-1:0]     dsel;
  logic [CID_W-1:0]     dptr;
  logic [CID_W-1:0]     gsel;
  logic [CID_W-1:0]     cptr;
  logic [N_CORES-1:0]   owned;
  logic [31:0]          q_cnt;
  logic [31:0]          r_cnt;

  logic                 d_gnt_vld;
  logic [CID_W-1:0]     d_gnt_idx;
  logic                 c_gnt_vld;
  logic [CID_W-1:0]     c_gnt_idx;
  logic [N_CORES-1:0]   avail;
  logic [N_CORES-1:0]   set_mask;
  logic [N_CORES-1:0]   clr_mask;
  logic                 s_fire;
  logic                 m_fire;

  function automatic logic [CID_W-1:0] wrap_inc(input logic [CID_W-1:0] idx);
    return (idx == CID_W'(N_CORES - 1)) ? '0 : idx + CID_W'(1);
  endfunction

  assign avail = ~owned & ~core_busy;

  dtw_rr_arbiter #(.N(N_CORES)) u_disp_arb (
    .req     (avail),
    .ptr     (dptr),
    .gnt_vld (d_gnt_vld),
    .gnt_idx (d_gnt_idx)
  );

  dtw_rr_arbiter #(.N(N_CORES)) u_coll_arb (
    .req     (core_res_valid),
    .ptr     (cptr),
    .gnt_vld (c_gnt_vld),
    .gnt_idx (c_gnt_idx)
  );

  // Stream muxing; clr forces every handshake low for its cycle.
  always_comb begin
    s_axis_tready  = 1'b0;
    core_src_wren  = '0;
    core_src_data  = '0;
    m_axis_tvalid  = 1'b0;
    m_axis_tdata   = '0;
    m_axis_tlast   = 1'b0;
    m_axis_tuser   = '0;
    core_res_ready = '0;
    if (dstate == D_STREAM) begin
      core_src_data = s_axis_tdata;
      s_axis_tready = !clr && !core_src_full[dsel];
      if (s_axis_tvalid && s_axis_tready) core_src_wren[dsel] = 1'b1;
    end
    if (cstate == C_PKT) begin
      m_axis_tvalid        = !clr && core_res_valid[gsel];
      m_axis_tdata         = core_res_data[32'(gsel) * AXIS_W +: AXIS_W];
      m_axis_tlast         = core_res_last[gsel];
      m_axis_tuser         = gsel;
      core_res_ready[gsel] = !clr && m_axis_tready;
    end
  end

  assign s_fire = s_axis_tvalid && s_axis_tready;
  assign m_fire = m_axis_tvalid && m_axis_tready;

  // Ownership updates: a new grant sets, a delivered result tlast clears.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (dstate == D_IDLE && en && d_gnt_vld) set_mask[d_gnt_idx] = 1'b1;
    if (m_fire && m_axis_tlast) clr_mask[gsel] = 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      dstate <= D_IDLE;
      cstate <= C_IDLE;
      dsel   <= '0;
      dptr   <= '0;
      gsel   <= '0;
      cptr   <= '0;
      owned  <= '0;
      q_cnt  <= '0;
      r_cnt  <= '0;
    end else if (clr) begin
      dstate <= D_IDLE;
      cstate <= C_IDLE;
      dsel   <= '0;
      dptr   <= '0;
      gsel   <= '0;
      cptr   <= '0;
      owned  <= '0;
      q_cnt  <= '0;
      r_cnt  <= '0;
    end else begin
      owned <= (owned & ~clr_mask) | set_mask;

      if (dstate == D_IDLE) begin
        if (en && d_gnt_vld) begin
          dsel   <= d_gnt_idx;
          dptr   <= wrap_inc(d_gnt_idx);
          dstate <= D_STREAM;
        end
      end else if (s_fire && s_axis_tlast) begin
        q_cnt  <= q_cnt + 32'd1;
        dstate <= D_IDLE;
      end

      // Grant is held for the whole packet so results never interleave.
      if (cstate == C_IDLE) begin
        if (c_gnt_vld) begin
          gsel   <= c_gnt_idx;
          cptr   <= wrap_inc(c_gnt_idx);
          cstate <= C_PKT;
        end
      end else if (m_fire && m_axis_tlast) begin
        r_cnt  <= r_cnt + 32'd1;
        cstate <= C_IDLE;
      end
    end
  end

  assign stat_owned = owned;
  assign stat_q_cnt = q_cnt;
  assign stat_r_cnt = r_cnt;

endmodule

// File: tb/tb_dtw_multi_dispatch.sv
// Directed plus randomized checks of dtw_multi_dispatch against a packet-level model.
module tb_dtw_multi_dispatch;

  localparam int N = 4;
  localparam int W = 32;

  logic           aclk = 1'b0;
  logic           aresetn;
  logic           en;
  logic           clr;
  logic [W-1:0]   s_axis_tdata;
  logic           s_axis_tvalid;
  logic           s_axis_tlast;
  logic           s_axis_tready;
  logic [W-1:0]   core_src_data;
  logic [N-1:0]   core_src_wren;
  logic [N-1:0]   core_src_full;
  logic [N-1:0]   core_busy;
  logic [N*W-1:0] core_res_data;
  logic [N-1:0]   core_res_valid;
  logic [N-1:0]   core_res_last;
  logic [N-1:0]   core_res_ready;
  logic [W-1:0]   m_axis_tdata;
  logic           m_axis_tvalid;
  logic           m_axis_tlast;
  logic [1:0]     m_axis_tuser;
  logic           m_axis_tready;
  logic [N-1:0]   stat_owned;
  logic [31:0]    stat_q_cnt;
  logic [31:0]    stat_r_cnt;

  always #5 aclk = ~aclk;

  dtw_multi_dispatch #(.N_CORES(N), .AXIS_W(W)) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .en             (en),
    .clr            (clr),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tready  (s_axis_tready),
    .core_src_data  (core_src_data),
    .core_src_wren  (core_src_wren),
    .core_src_full  (core_src_full),
    .core_busy      (core_busy),
    .core_res_data  (core_res_data),
    .core_res_valid (core_res_valid),
    .core_res_last  (core_res_last),
    .core_res_ready (core_res_ready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tready  (m_axis_tready),
    .stat_owned     (stat_owned),
    .stat_q_cnt     (stat_q_cnt),
    .stat_r_cnt     (stat_r_cnt)
  );

  int vectors = 0;
  int miscompares = 0;
  int proto_err = 0;

  // Transfer logs: {core, data, last}
  logic [34:0] src_log[$];
  logic [34:0] out_log[$];
  int          mon_idx;

  always @(negedge aclk) begin
    if (aresetn) begin
      if (s_axis_tvalid && s_axis_tready) begin
        mon_idx = 0;
        for (int i = 0; i < N; i++) if (core_src_wren[i]) mon_idx = i;
        if ($countones(core_src_wren) != 1) proto_err++;
        src_log.push_back({2'(mon_idx), core_src_data, s_axis_tlast});
      end else if (core_src_wren != '0) begin
        proto_err++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (core_res_ready != (4'b0001 << m_axis_tuser)) proto_err++;
        out_log.push_back({m_axis_tuser, m_axis_tdata, m_axis_tlast});
      end
    end
  end

  // Behavioural result sources: one small FIFO per core.
  logic [32:0] res_mem [N][16];
  int          res_wr [N];
  int          res_rd [N];
  logic [N-1:0] pops;

  always begin
    @(negedge aclk);
    pops = core_res_valid & core_res_ready;
    @(posedge aclk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (!aresetn) res_rd[i] = res_wr[i];
      else if (pops[i]) res_rd[i] = res_rd[i] + 1;
      if (res_rd[i] != res_wr[i]) begin
        {core_res_last[i], core_res_data[i*W +: W]} = res_mem[i][res_rd[i] % 16];
        core_res_valid[i] = 1'b1;
      end else begin
        core_res_last[i]        = 1'b0;
        core_res_data[i*W +: W] = '0;
        core_res_valid[i]       = 1'b0;
      end
    end
  end

  // Packet-level reference model.
  logic [3:0] m_owned;
  int         m_ptr, m_q, m_r;
  logic [31:0] qw [16];
  logic [31:0] rw [16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic model_dispatch(input logic [3:0] busy, output int c);
    int cand;
    c = -1;
    for (int k = 0; k < N; k++) begin
      cand = (m_ptr + k) % N;
      if (c < 0 && !m_owned[cand] && !busy[cand]) c = cand;
    end
    if (c >= 0) begin
      m_owned[c] = 1'b1;
      m_ptr      = (c + 1) % N;
    end
  endtask

  task automatic model_return(input int c);
    m_owned[c] = 1'b0;
    m_r++;
  endtask

  task automatic sample_stats(input string tag);
    @(negedge aclk);
    check({tag, "_q_cnt"}, stat_q_cnt, 64'(m_q));
    check({tag, "_r_cnt"}, stat_r_cnt, 64'(m_r));
    check({tag, "_owned"}, stat_owned, m_owned);
    step();
  endtask

  // Offer qw[0..send-1] of a len-word query; en drops after the first beat.
  task automatic send_query(input int len, input bit rnd, input int stall_at,
                            input int stall_cyc, input int send);
    bit acc;
    int guard;
    en = 1'b1;
    for (int k = 0; k < send; k++) begin
      if (rnd) repeat ($urandom_range(0, 2)) begin s_axis_tvalid = 1'b0; step(); end
      s_axis_tdata  = qw[k];
      s_axis_tlast  = (k == len - 1);
      s_axis_tvalid = 1'b1;
      if (k == stall_at) begin
        core_src_full = '1;
        repeat (stall_cyc) begin
          @(negedge aclk);
          check("stall_tready", s_axis_tready, 0);
          step();
        end
        core_src_full = '0;
      end
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 200) begin
        @(negedge aclk);
        acc = s_axis_tready;
        step();
        guard++;
        if (!acc && rnd) core_src_full = ($urandom_range(0, 2) == 0) ? 4'hF : 4'h0;
      end
      core_src_full = '0;
      check("query_accept", acc, 1);
      if (!acc) break;
      if (k == 0) en = 1'b0;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    en            = 1'b0;
  endtask

  task automatic expect_query(input int core, input int cnt, input int total, input string tag);
    logic [34:0] e;
    check({tag, "_len"}, src_log.size(), 64'(cnt));
    for (int k = 0; k < cnt; k++) begin
      e = (src_log.size() > 0) ? src_log.pop_front() : '1;
      check(tag, e, {2'(core), qw[k], (k == total - 1)});
    end
    src_log.delete();
  endtask

  task automatic push_result(input int core, input int off, input int len);
    for (int k = 0; k < len; k++) begin
      res_mem[core][res_wr[core] % 16] = {(k == len - 1), rw[off + k]};
      res_wr[core] = res_wr[core] + 1;
    end
  endtask

  // mode 0: ready=1, 1: ready toggles 1010.., 2: random ready
  task automatic drain(input int n_words, input int mode, input bit chk_block);
    int cyc;
    int del;
    cyc = 0;
    del = 0;
    while (del < n_words && cyc < 300) begin
      m_axis_tready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      @(negedge aclk);
      if (chk_block) check("blocked_tready", s_axis_tready, 0);
      if (mode == 1 && m_axis_tvalid) check("held_tdata", m_axis_tdata, rw[del]);
      if (m_axis_tvalid && m_axis_tready) del++;
      step();
      cyc++;
    end
    m_axis_tready = 1'b0;
    check("drain_done", del, 64'(n_words));
  endtask

  task automatic expect_out(input int core, input int off, input int cnt, input int total,
                            input string tag);
    logic [34:0] e;
    for (int k = 0; k < cnt; k++) begin
      e = (out_log.size() > 0) ? out_log.pop_front() : '1;
      check(tag, e, {2'(core), rw[off + k], (k == total - 1)});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int len;
    logic [3:0] busy;

    aresetn = 1'b0; en = 1'b0; clr = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    core_src_full = '0; core_busy = '0; m_axis_tready = 1'b0;
    core_res_data = '0; core_res_valid = '0; core_res_last = '0;
    for (int i = 0; i < N; i++) begin res_wr[i] = 0; res_rd[i] = 0; end
    m_owned = '0; m_ptr = 0; m_q = 0; m_r = 0;

    // Reset state
    repeat (3) step();
    @(negedge aclk);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_wren", core_src_wren, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_res_ready", core_res_ready, 0);
    check("rst_tuser", m_axis_tuser, 0);
    check("rst_owned", stat_owned, 0);
    check("rst_q_cnt", stat_q_cnt, 0);
    check("rst_r_cnt", stat_r_cnt, 0);
    step();
    aresetn = 1'b1;
    step();

    // Four 3-word queries land on cores 0..3 in order
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 3; k++) qw[k] = $urandom;
      model_dispatch(4'b0000, c);
      send_query(3, 1'b0, -1, 0, 3);
      m_q++;
      expect_query(i, 3, 3, "t1_query");
    end
    sample_stats("t1");

    // Core 1 busy; fifth query waits for core 0's result
    core_busy = 4'b0010;
    for (int k = 0; k < 2; k++) rw[k] = $urandom;
    push_result(1, 0, 2);
    drain(2, 0, 1'b0);
    expect_out(1, 0, 2, 2, "t2_res1");
    model_return(1);
    for (int k = 0; k < 3; k++) qw[k] = $urandom;
    en = 1'b1;
    s_axis_tdata = qw[0]; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
    repeat (6) begin
      @(negedge aclk);
      check("t2_wait_tready", s_axis_tready, 0);
      step();
    end
    for (int k = 0; k < 2; k++) rw[k] = $urandom;
    push_result(0, 0, 2);
    drain(2, 0, 1'b1);
    expect_out(0, 0, 2, 2, "t2_res0");
    model_return(0);
    model_dispatch(4'b0010, c);
    send_query(3, 1'b0, -1, 0, 3);
    m_q++;
    expect_query(0, 3, 3, "t2_query");
    sample_stats("t2");

    // Cores 2 and 3 raise results together: no interleave, lower pointer first
    core_busy = 4'b0000;
    for (int k = 0; k < 4; k++) rw[k] = $urandom;
    push_result(2, 0, 2);
    push_result(3, 2, 2);
    drain(4, 0, 1'b0);
    expect_out(2, 0, 2, 2, "t3_res2");
    expect_out(3, 2, 2, 2, "t3_res3");
    model_return(2);
    model_return(3);
    sample_stats("t3");

    // src FIFO full for 5 cycles mid-query
    for (int k = 0; k < 4; k++) qw[k] = $urandom;
    model_dispatch(4'b0000, c);
    send_query(4, 1'b0, 2, 5, 4);
    m_q++;
    expect_query(1, 4, 4, "t4_query");
    sample_stats("t4");

    // m_axis_tready toggling during a 4-word result
    for (int k = 0; k < 4; k++) rw[k] = $urandom;
    push_result(0, 0, 4);
    drain(4, 1, 1'b0);
    expect_out(0, 0, 4, 4, "t5_res");
    model_return(0);
    sample_stats("t5");

    // Randomized mix of queries and results
    for (int it = 0; it < 24; it++) begin
      if (m_owned == 4'hF || $urandom_range(0, 2) == 0) begin
        c   = $urandom_range(0, 3);
        len = $urandom_range(1, 4);
        for (int k = 0; k < len; k++) rw[k] = $urandom;
        push_result(c, 0, len);
        drain(len, 2, 1'b0);
        expect_out(c, 0, len, len, "rnd_res");
        model_return(c);
      end else begin
        busy = 4'($urandom_range(0, 15));
        if ((~m_owned & ~busy) == 4'h0) busy = 4'h0;
        core_busy = busy;
        len = $urandom_range(1, 5);
        for (int k = 0; k < len; k++) qw[k] = $urandom;
        model_dispatch(busy, c);
        send_query(len, 1'b1, -1, 0, len);
        m_q++;
        core_busy = '0;
        expect_query(c, len, len, "rnd_query");
      end
      sample_stats("rnd");
    end

    // clr mid-query abandons it and zeroes everything
    for (int k = 0; k < 4; k++) qw[k] = $urandom;
    model_dispatch(4'b0000, c);
    send_query(4, 1'b0, -1, 0, 2);
    s_axis_tdata = qw[2]; s_axis_tvalid = 1'b1; clr = 1'b1;
    @(negedge aclk);
    check("t6_clr_tready", s_axis_tready, 0);
    check("t6_clr_wren", core_src_wren, 0);
    step();
    clr = 1'b0; s_axis_tvalid = 1'b0;
    expect_query(c, 2, 4, "t6_partial");
    m_owned = '0; m_ptr = 0; m_q = 0; m_r = 0;
    sample_stats("t6_clr");

    // aresetn mid-result
    for (int k = 0; k < 4; k++) rw[k] = $urandom;
    push_result(3, 0, 4);
    begin
      int del;
      int cyc;
      del = 0;
      cyc = 0;
      m_axis_tready = 1'b1;
      while (del < 2 && cyc < 50) begin
        @(negedge aclk);
        if (m_axis_tvalid && m_axis_tready) del++;
        step();
        cyc++;
      end
      check("t6_partial_res", del, 2);
    end
    #2 aresetn = 1'b0;
    @(negedge aclk);
    check("t6_rst_m_tvalid", m_axis_tvalid, 0);
    check("t6_rst_res_ready", core_res_ready, 0);
    check("t6_rst_tdata", m_axis_tdata, 0);
    check("t6_rst_s_tready", s_axis_tready, 0);
    check("t6_rst_r_cnt", stat_r_cnt, 0);
    check("t6_rst_owned", stat_owned, 0);
    step();
    step();
    aresetn = 1'b1;
    m_axis_tready = 1'b0;
    expect_out(3, 0, 2, 4, "t6_res_pre_rst");
    out_log.delete();
    step();
    for (int k = 0; k < 3; k++) qw[k] = $urandom;
    model_dispatch(4'b0000, c);
    send_query(3, 1'b0, -1, 0, 3);
    m_q++;
    expect_query(0, 3, 3, "t6_post_query");
    sample_stats("t6_end");

    check("protocol_errors", proto_err, 0);
    check("leftover_results", out_log.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
